// File: rtl/dut_arb_pkg.sv
// Shared types and constants for the two-master DUT port arbiter.
// The optional ISSUE timeout in dut_port_arbiter is enabled by ARB_TIMEOUT_EN.
package dut_arb_pkg;

    localparam int unsigned ADDR_W             = 3;
    localparam int unsigned NUM_M              = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic              wdata;
    } arb_cmd_t;

    function automatic logic [NUM_M-1:0] idx_to_onehot(input logic idx);
        logic [NUM_M-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dut_arb_rr.sv
// Two-way round-robin grant: the pointer names the master with priority and
// moves to the non-granted master on every accept.
module dut_arb_rr
    import dut_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NUM_M-1:0] req_i,
    input  logic             accept_i,
    output logic             grant_valid_o,
    output logic             grant_idx_o,
    output logic [NUM_M-1:0] grant_oh_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_valid_o = |req_i;
        grant_idx_o   = ptr_q;
        if (!req_i[ptr_q]) begin
            grant_idx_o = ~ptr_q;
        end
        grant_oh_o = grant_valid_o ? idx_to_onehot(grant_idx_o) : '0;
        ptr_d      = accept_i ? ~grant_idx_o : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dut_port_arbiter.sv
// Arbitrates two masters onto a single DUT write/read method port (IDLE/ISSUE/RESP).
// Define ARB_TIMEOUT_EN to abort an ISSUE after TIMEOUT_CYCLES cycles without DUT ready.
module dut_port_arbiter
    import dut_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_M-1:0]        m_req_valid,
    output logic [NUM_M-1:0]        m_req_ready,
    input  logic [NUM_M-1:0]        m_req_write,
    input  logic [NUM_M*ADDR_W-1:0] m_req_addr,
    input  logic [NUM_M-1:0]        m_req_wdata,
    output logic [NUM_M-1:0]        m_resp_valid,
    output logic                    m_resp_rdata,
    output logic                    m_resp_err,
    output logic [ADDR_W-1:0]       write_address,
    output logic                    write_data,
    output logic                    write_en,
    input  logic                    write_rdy,
    output logic [ADDR_W-1:0]       read_address,
    output logic                    read_en,
    input  logic                    read_data,
    input  logic                    read_rdy,
    output logic                    busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dut_port_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e       state_q;
    arb_cmd_t         cmd_q;
    logic             grant_q;
    logic [NUM_M-1:0] resp_valid_q;
    logic             resp_rdata_q;

    logic             in_idle;
    logic             in_issue;
    logic             accept;
    logic             fire;
    logic             grant_valid;
    logic             grant_idx;
    logic [NUM_M-1:0] grant_oh;
    arb_cmd_t         req_cmd;

    assign in_idle  = (state_q == IDLE);
    assign in_issue = (state_q == ISSUE);
    // RST gates the accept so m_req_ready stays low for the whole reset window.
    assign accept   = in_idle & ~RST & grant_valid;

    dut_arb_rr u_rr (
        .clk_i         (CLK),
        .rst_i         (RST),
        .req_i         (m_req_valid),
        .accept_i      (accept),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .grant_oh_o    (grant_oh)
    );

    always_comb begin
        req_cmd       = '0;
        req_cmd.write = m_req_write[grant_idx];
        req_cmd.addr  = m_req_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
        req_cmd.wdata = m_req_wdata[grant_idx];
    end

    assign m_req_ready = accept ? grant_oh : '0;

    assign write_en      = in_issue &  cmd_q.write & write_rdy;
    assign read_en       = in_issue & ~cmd_q.write & read_rdy;
    assign fire          = write_en | read_en;
    assign write_address = (in_issue &  cmd_q.write) ? cmd_q.addr : '0;
    assign write_data    = in_issue &  cmd_q.write & cmd_q.wdata;
    assign read_address  = (in_issue & ~cmd_q.write) ? cmd_q.addr : '0;

    assign m_resp_valid  = resp_valid_q;
    assign m_resp_rdata  = resp_rdata_q;
    assign busy          = ~in_idle;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout;
    logic            resp_err_q;

    assign timeout    = in_issue & ~fire & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign m_resp_err = resp_err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if (in_issue) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign m_resp_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            grant_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            // Response fields are one-cycle strobes; only the ISSUE exit sets them.
            resp_valid_q <= '0;
            resp_rdata_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ISSUE;
                        grant_q <= grant_idx;
                        cmd_q   <= req_cmd;
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        state_q      <= RESP;
                        resp_valid_q <= idx_to_onehot(grant_q);
                        resp_rdata_q <= read_en & read_data;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (timeout) begin
                        state_q      <= RESP;
                        resp_valid_q <= idx_to_onehot(grant_q);
                        resp_err_q   <= 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    a_en_exclusive : assert property (@(posedge CLK) disable iff (RST)
        !(write_en && read_en));
    a_ready_onehot : assert property (@(posedge CLK) disable iff (RST)
        $onehot0(m_req_ready));
    a_resp_onehot  : assert property (@(posedge CLK) disable iff (RST)
        $onehot0(m_resp_valid));

endmodule

// File: tb/tb_dut_port_arbiter.sv
// Directed self-checking bench for dut_port_arbiter; the timeout scenario runs
// only when ARB_TIMEOUT_EN is defined.
module tb_dut_port_arbiter;

    localparam int unsigned TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL = 3;
`else
    localparam int unsigned STALL = 5;
`endif

    logic       CLK;
    logic       RST;
    logic [1:0] m_req_valid;
    logic [1:0] m_req_ready;
    logic [1:0] m_req_write;
    logic [5:0] m_req_addr;
    logic [1:0] m_req_wdata;
    logic [1:0] m_resp_valid;
    logic       m_resp_rdata;
    logic       m_resp_err;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    dut_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req_write   (m_req_write),
        .m_req_addr    (m_req_addr),
        .m_req_wdata   (m_req_wdata),
        .m_resp_valid  (m_resp_valid),
        .m_resp_rdata  (m_resp_rdata),
        .m_resp_err    (m_resp_err),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .busy          (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        m_req_valid = '0;
        m_req_write = '0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        write_rdy   = 1'b0;
        read_rdy    = 1'b0;
        read_data   = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        m_req_valid = 2'b11;
        write_rdy   = 1'b1;
        read_rdy    = 1'b1;
        tick();
        tick();
        check("rst_ready", m_req_ready, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_wen", write_en, 0);
        check("rst_ren", read_en, 0);
        check("rst_resp", m_resp_valid, 2'b00);
        check("rst_waddr", write_address, 0);
        clear_inputs();
        RST = 1'b0;

        // M0 write addr 4 data 1, DUT ready
        m_req_valid = 2'b01; m_req_write = 2'b01; m_req_addr = {3'd0, 3'd4};
        m_req_wdata = 2'b01; write_rdy = 1'b1;
        #1;
        check("wr_ready", m_req_ready, 2'b01);
        tick();
        m_req_valid = 2'b00; m_req_addr = 6'h3f; m_req_wdata = 2'b00;
        #1;
        check("wr_en", write_en, 1);
        check("wr_addr", write_address, 4);
        check("wr_data", write_data, 1);
        check("wr_no_ren", read_en, 0);
        check("wr_busy", busy, 1);
        tick();
        check("wr_en_resp", write_en, 0);
        check("wr_resp", m_resp_valid, 2'b01);
        check("wr_err", m_resp_err, 0);
        check("wr_rdata", m_resp_rdata, 0);
        tick();
        check("wr_resp_done", m_resp_valid, 2'b00);
        check("wr_idle", busy, 0);
        clear_inputs();

        // M1 read addr 3, read_data 1
        m_req_valid = 2'b10; m_req_addr = {3'd3, 3'd0}; read_rdy = 1'b1; read_data = 1'b1;
        #1;
        check("rd_ready", m_req_ready, 2'b10);
        tick();
        m_req_valid = 2'b00;
        #1;
        check("rd_en", read_en, 1);
        check("rd_addr", read_address, 3);
        check("rd_no_wen", write_en, 0);
        tick();
        check("rd_en_resp", read_en, 0);
        check("rd_resp", m_resp_valid, 2'b10);
        check("rd_rdata", m_resp_rdata, 1);
        tick();
        clear_inputs();

        // Fresh reset, both masters requesting continuously: M0, M1, M0, M1
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_req_valid = 2'b11; m_req_addr = {3'd6, 3'd1}; read_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", m_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check("rr_addr", read_address, (i % 2 == 0) ? 3'd1 : 3'd6);
            tick();
            check("rr_resp", m_resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        clear_inputs();

        // Write stalled by write_rdy low, then fires once
        m_req_valid = 2'b01; m_req_write = 2'b01; m_req_addr = {3'd0, 3'd2};
        #1;
        check("stall_ready", m_req_ready, 2'b01);
        tick();
        m_req_valid = 2'b00;
        for (int i = 0; i < int'(STALL); i++) begin
            #1;
            check("stall_wen", write_en, 0);
            check("stall_resp", m_resp_valid, 2'b00);
            tick();
        end
        write_rdy = 1'b1;
        #1;
        check("stall_fire", write_en, 1);
        check("stall_addr", write_address, 2);
        check("stall_data", write_data, 0);
        tick();
        check("stall_resp_out", m_resp_valid, 2'b01);
        check("stall_err", m_resp_err, 0);
        tick();
        clear_inputs();

        // Reset mid-ISSUE: enable drops at once, no response, pointer back to M0
        m_req_valid = 2'b01; m_req_write = 2'b01; m_req_addr = {3'd0, 3'd7}; m_req_wdata = 2'b01;
        #1;
        check("abort_ready", m_req_ready, 2'b01);
        tick();
        m_req_valid = 2'b00; write_rdy = 1'b1;
        #1;
        check("abort_wen_pre", write_en, 1);
        RST = 1'b1;
        #1;
        check("abort_wen", write_en, 0);
        check("abort_busy", busy, 0);
        check("abort_waddr", write_address, 0);
        check("abort_wdata", write_data, 0);
        tick();
        RST = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("abort_no_resp", m_resp_valid, 2'b00);
            tick();
        end
        m_req_valid = 2'b11; read_rdy = 1'b1;
        #1;
        check("abort_ptr", m_req_ready, 2'b01);
        tick();
        m_req_valid = 2'b00;
        tick();
        tick();
        clear_inputs();

`ifdef ARB_TIMEOUT_EN
        // Read with read_rdy stuck low times out after TO ISSUE cycles
        m_req_valid = 2'b10; m_req_addr = {3'd5, 3'd0}; read_data = 1'b1;
        #1;
        check("to_ready", m_req_ready, 2'b10);
        tick();
        m_req_valid = 2'b00;
        for (int i = 0; i < int'(TO); i++) begin
            #1;
            check("to_ren", read_en, 0);
            check("to_no_resp", m_resp_valid, 2'b00);
            tick();
        end
        check("to_resp", m_resp_valid, 2'b10);
        check("to_err", m_resp_err, 1);
        check("to_rdata", m_resp_rdata, 0);
        check("to_ren_resp", read_en, 0);
        tick();
        m_req_valid = 2'b10; read_rdy = 1'b1;
        #1;
        check("to_next_ready", m_req_ready, 2'b10);
        tick();
        m_req_valid = 2'b00;
        #1;
        check("to_next_ren", read_en, 1);
        tick();
        check("to_next_resp", m_resp_valid, 2'b10);
        check("to_next_err", m_resp_err, 0);
        check("to_next_rdata", m_resp_rdata, 1);
        tick();
        clear_inputs();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
